bomb_controller: RTL

Places a single bomb on the tile grid when the player presses the action button, runs its fuse, then produces the explosion. It sits directly upstream of the player-movement block. It feeds that block `e_x`, `e_y` and the one-cycle `explosion_SCEN` pulse used for the hit test. It also tells the top level which pixels to draw as the bomb sprite or the blast plus-shape.

---
 rtl/bomb_controller_pkg.sv | 35 +++
 rtl/bomb_rom.sv | 37 +++
 rtl/bomb_controller.sv | 133 +++++++++++++
 3 files changed

// File: rtl/bomb_controller_pkg.sv
// Shared display bounds, tile geometry and bomb FSM encoding used by the bomb,
// player and collision blocks.
package bomb_controller_pkg;

  localparam logic [9:0] MIN_X = 10'd143;
  localparam logic [9:0] MAX_X = 10'd784;
  localparam logic [9:0] MIN_Y = 10'd34;
  localparam logic [9:0] MAX_Y = 10'd516;

  localparam int         TILE       = 16;
  localparam int         TILE_SHIFT = 4;
  localparam logic [10:0] TILE_LAST = 11'(TILE - 1);
  localparam logic [10:0] ARM_NEAR  = 11'd48;
  localparam logic [10:0] ARM_FAR   = 11'd63;

  localparam logic [11:0] BLAST_RGB = 12'hF80;
  localparam logic [11:0] BODY_RGB  = 12'h333;
  localparam logic [11:0] SHINE_RGB = 12'hCCC;
  localparam logic [11:0] SPARK_RGB = 12'hFA0;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    FUSE  = 2'b01,
    BLAST = 2'b10
  } bomb_state_t;

  // Round a sprite coordinate to the nearest tile origin inside the field.
  function automatic logic [9:0] snap_to_tile(input logic [9:0] pos,
                                              input logic [9:0] origin);
    logic [9:0] idx;
    idx = (pos - origin + 10'd8) >> TILE_SHIFT;
    return origin + (idx << TILE_SHIFT);
  endfunction

endpackage

// File: rtl/bomb_rom.sv
// 16x16 bomb sprite, 12-bit colour, registered read port.
module bomb_rom
  import bomb_controller_pkg::*;
(
  input  logic        clk,
  input  logic [3:0]  row,
  input  logic [3:0]  col,
  output logic [11:0] color_data
);

  function automatic logic [15:0] body_mask(input logic [3:0] r);
    case (r)
      4'd3, 4'd14:                               body_mask = 16'h07E0;
      4'd4, 4'd13:                               body_mask = 16'h1FF8;
      4'd5, 4'd12:                               body_mask = 16'h3FFC;
      4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd11:      body_mask = 16'h7FFE;
      default:                                   body_mask = 16'h0000;
    endcase
  endfunction

  function automatic logic [11:0] sprite_pixel(input logic [3:0] r,
                                               input logic [3:0] c);
    logic [15:0] mask;
    mask = body_mask(r);
    if (r == 4'd5 && c == 4'd5)       return SHINE_RGB;
    else if (mask[c])                 return BODY_RGB;
    else if (r <= 4'd2 && c == 4'd8)  return SPARK_RGB;
    else                              return 12'h000;
  endfunction

  // NOTE: ROM output register carries no reset; its contents are a pure
  // function of the address, so it needs none and maps onto block RAM.
  always_ff @(posedge clk) begin
    color_data <= sprite_pixel(row, col);
  end

endmodule

// File: rtl/bomb_controller.sv
// Single-bomb place/fuse/blast controller with sprite and blast-shape pixel
// generation for the VGA path.
module bomb_controller
  import bomb_controller_pkg::*;
#(
  parameter int FUSE_CYCLES  = 200_000_000,
  parameter int BLAST_CYCLES = 50_000_000,
  parameter int CNT_W        = 28
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        C,
  input  logic        game_over,
  input  logic [9:0]  b_x,
  input  logic [9:0]  b_y,
  input  logic [9:0]  v_x,
  input  logic [9:0]  v_y,
  output logic [9:0]  e_x,
  output logic [9:0]  e_y,
  output logic        explosion_SCEN,
  output logic        bomb_active,
  output logic        bomb_on,
  output logic        blast_on,
  output logic [11:0] rgb_out
);

  localparam logic [CNT_W-1:0] FUSE_LAST  = CNT_W'(FUSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLAST_LAST = CNT_W'(BLAST_CYCLES - 1);

  bomb_state_t      state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [9:0]       e_x_n, e_y_n;
  logic             scen_n;
  logic             c_q;
  logic             c_rise;
  logic             bomb_on_q;
  logic [11:0]      color_data;

  assign c_rise = C & ~c_q;

  // NOTE: every always_comb output gets a default first so no path can hold
  // a value, which would otherwise infer a latch.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    e_x_n   = e_x;
    e_y_n   = e_y;
    scen_n  = 1'b0;
    case (state)
      IDLE: begin
        if (c_rise && !game_over) begin
          state_n = FUSE;
          cnt_n   = '0;
          e_x_n   = snap_to_tile(b_x, MIN_X);
          e_y_n   = snap_to_tile(b_y, MIN_Y);
        end
      end
      FUSE: begin
        if (cnt == FUSE_LAST) begin
          state_n = BLAST;
          cnt_n   = '0;
          scen_n  = 1'b1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      BLAST: begin
        if (cnt == BLAST_LAST) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update from the same pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      cnt            <= '0;
      c_q            <= 1'b0;
      e_x            <= MIN_X;
      e_y            <= MIN_Y;
      explosion_SCEN <= 1'b0;
      bomb_on_q      <= 1'b0;
    end else begin
      state          <= state_n;
      cnt            <= cnt_n;
      c_q            <= C;
      e_x            <= e_x_n;
      e_y            <= e_y_n;
      explosion_SCEN <= scen_n;
      bomb_on_q      <= bomb_on;
    end
  end

  assign bomb_active = (state == FUSE);

  // Widen to 11 bits so v+48 and e+63 cannot wrap near the far walls.
  logic [10:0] vx, vy, ex, ey;
  logic        in_row, in_col, h_arm, v_arm, in_field;

  assign vx = {1'b0, v_x};
  assign vy = {1'b0, v_y};
  assign ex = {1'b0, e_x};
  assign ey = {1'b0, e_y};

  assign in_row   = (vy >= ey) && (vy <= ey + TILE_LAST);
  assign in_col   = (vx >= ex) && (vx <= ex + TILE_LAST);
  assign h_arm    = in_row && (vx + ARM_NEAR >= ex) && (vx <= ex + ARM_FAR);
  assign v_arm    = in_col && (vy + ARM_NEAR >= ey) && (vy <= ey + ARM_FAR);
  assign in_field = (v_x >= MIN_X) && (v_x < MAX_X) &&
                    (v_y >= MIN_Y) && (v_y < MAX_Y);

  assign bomb_on  = (state == FUSE)  && in_row && in_col;
  assign blast_on = (state == BLAST) && (h_arm || v_arm) && in_field;

  // Inside the sprite the low nibbles of v-e equal the full difference.
  bomb_rom u_bomb_rom (
    .clk        (clk),
    .row        (v_y[3:0] - e_y[3:0]),
    .col        (v_x[3:0] - e_x[3:0]),
    .color_data (color_data)
  );

  assign rgb_out = blast_on  ? BLAST_RGB  :
                   bomb_on_q ? color_data : 12'h000;

endmodule
